axi_wr_arbiter: RTL
===================

# axi_wr_arbiter

Round-robin write-channel arbiter sharing one AXI write port (AW, W, B) between NUM_M upstream masters in the AXI interconnect. Each transaction is granted one at a time and held until its write response completes, so W beats and B responses never interleave between masters. The block regenerates WLAST from AWLEN and flags masters whose WLAST disagrees with the burst length.

## Interface
Parameters:
- NUM_M, 2: number of upstream masters (2..8).
- ID_WIDTH, 4: AXI ID width, passed through unchanged.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- STRB_WIDTH, DATA_WIDTH/8: write strobe width.

Ports (s_* are per-master, packed with master i at slice i; m_* is the shared downstream side):
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- s_awid / s_awaddr / s_awlen  in  NUM_M*ID_WIDTH / NUM_M*ADDR_WIDTH / NUM_M*8  per-master AW payload.
- s_awvalid  in  NUM_M;  s_awready  out  NUM_M.
- s_wdata / s_wstrb  in  NUM_M*DATA_WIDTH / NUM_M*STRB_WIDTH  per-master W payload.
- s_wlast, s_wvalid  in  NUM_M;  s_wready  out  NUM_M.
- s_bid  out  NUM_M*ID_WIDTH;  s_bresp  out  NUM_M*2;  s_bvalid  out  NUM_M;  s_bready  in  NUM_M.
- m_awid / m_awaddr / m_awlen  out  ID_WIDTH / ADDR_WIDTH / 8;  m_awvalid  out  1;  m_awready  in  1.
- m_wdata / m_wstrb  out  DATA_WIDTH / STRB_WIDTH;  m_wlast, m_wvalid  out  1;  m_wready  in  1.
- m_bid  in  ID_WIDTH;  m_bresp  in  2;  m_bvalid  in  1;  m_bready  out  1.
- grant  out  NUM_M  one-hot owner of the port; 0 in IDLE.
- len_err  out  NUM_M  sticky per-master WLAST/AWLEN mismatch flag.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Registers: grant index g, last_grant, beat counter cnt[7:0], latched len[7:0].
- IDLE: if any s_awvalid is set, pick the first requester after last_grant in circular order. Register g and grant, then go to ADDR. If nothing is requested, stay in IDLE.
- ADDR: m_awvalid=1; m_aw* = slice g; s_awready[g]=m_awready. On m_awvalid&m_awready, latch len=s_awlen[g], set cnt=0, go to DATA.
- DATA: m_wvalid=s_wvalid[g]; m_wdata/m_wstrb = slice g; s_wready[g]=m_wready; m_wlast=(cnt==len).
  - Each beat handshake increments cnt.
  - On a beat with cnt==len, go to RESP.
  - If s_wlast[g]!=(cnt==len) on any handshaken beat, set len_err[g]. The burst still ends on the AWLEN count.
- RESP: m_bready=s_bready[g]; s_bvalid[g]=m_bvalid; s_bid/s_bresp of slice g = m_bid/m_bresp. On the B handshake, last_grant<=g, grant<=0, go to IDLE.
- Non-granted masters: all s_*ready and s_bvalid are 0; s_bid/s_bresp are 0.
- len_err bits clear only on reset.

## Timing
- Reset (reset=0 at a clk edge): state=IDLE, grant=0, last_grant=NUM_M-1 (so master 0 wins first), cnt=0, len=0, len_err=0. All m_*valid, m_bready, s_*ready and s_bvalid are 0; all payload outputs are 0.
- Reset mid-transaction aborts immediately, with no cleanup of the downstream port.
- Arbitration latency: s_awvalid seen in IDLE at edge N puts m_awvalid high from cycle N+1.
- AW, W and B are combinational pass-throughs of valid/ready while in the matching state; there are no extra pipeline stages.
- Minimum transaction: IDLE(1) + ADDR(1) + DATA(len+1 beats) + RESP(1), so the next grant earliest comes 4+len cycles after the first request.
- A single outstanding transaction at a time: AW is never accepted while DATA or RESP is active.
- W beats offered by a master before its grant reaches DATA are stalled (s_wready=0).
- AWLEN=255 gives 256 beats; cnt must not wrap before the compare.
- A requester that drops s_awvalid after the grant is still held in ADDR (AXI forbids this; no recovery).

## Test plan
- Single request: m0 issues AWLEN=3 with 4 beats and m_*ready tied to 1 -> m_awvalid at cycle 1, m_wlast only on the 4th beat, s_bvalid[0] mirrors m_bvalid, grant returns to 0, len_err=0.
- Round-robin: m0 and m1 request continuously with AWLEN=0 -> grant sequence 01, 10, 01, 10; neither master is starved.
- Backpressure: m_wready toggles 1,0,1,0 during an 8-beat burst from m1 -> exactly 8 beats forwarded in order, data unchanged, m_wlast on beat 8.
- Length mismatch: m0 sends AWLEN=1 with s_wlast on beat 1 -> len_err[0]=1, m_wlast on beat 2 only, and the transaction completes normally.
- Max burst: AWLEN=255 -> 256 beats, m_wlast on beat 256, no early exit.
- Reset mid-DATA: reset=0 for one cycle after beat 2 -> all outputs 0 next cycle, state IDLE, master 0 granted first afterwards.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write port (AW/W/B) among NUM_M masters.
// Ports: clk/reset, packed per-master s_* (slice i = master i), shared m_*, grant, len_err.
module axi_wr_arbiter #(
  parameter int NUM_M      = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_M*ID_WIDTH-1:0]    s_awid,
  input  logic [NUM_M*ADDR_WIDTH-1:0]  s_awaddr,
  input  logic [NUM_M*8-1:0]           s_awlen,
  input  logic [NUM_M-1:0]             s_awvalid,
  output logic [NUM_M-1:0]             s_awready,
  input  logic [NUM_M*DATA_WIDTH-1:0]  s_wdata,
  input  logic [NUM_M*STRB_WIDTH-1:0]  s_wstrb,
  input  logic [NUM_M-1:0]             s_wlast,
  input  logic [NUM_M-1:0]             s_wvalid,
  output logic [NUM_M-1:0]             s_wready,
  output logic [NUM_M*ID_WIDTH-1:0]    s_bid,
  output logic [NUM_M*2-1:0]           s_bresp,
  output logic [NUM_M-1:0]             s_bvalid,
  input  logic [NUM_M-1:0]             s_bready,
  output logic [ID_WIDTH-1:0]          m_awid,
  output logic [ADDR_WIDTH-1:0]        m_awaddr,
  output logic [7:0]                   m_awlen,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic [STRB_WIDTH-1:0]        m_wstrb,
  output logic                         m_wlast,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic [ID_WIDTH-1:0]          m_bid,
  input  logic [1:0]                   m_bresp,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  output logic [NUM_M-1:0]             grant,
  output logic [NUM_M-1:0]             len_err
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [GW-1:0]    r_g;
  logic [GW-1:0]    r_last;
  logic [7:0]       r_cnt;
  logic [7:0]       r_len;
  logic [NUM_M-1:0] r_grant;
  logic [NUM_M-1:0] r_len_err;

  logic [GW-1:0]    w_hi;
  logic [GW-1:0]    w_lo;
  logic             w_hi_v;
  logic             w_lo_v;
  logic             w_any;
  logic [GW-1:0]    w_pick;
  logic [NUM_M-1:0] w_onehot;
  logic             w_w_hs;
  logic             w_b_hs;
  logic             w_at_end;

  // Circular priority: lowest index above r_last wins,
  // else wrap to the lowest index at or below r_last.
  always_comb begin
    w_hi   = '0;
    w_lo   = '0;
    w_hi_v = 1'b0;
    w_lo_v = 1'b0;
    for (int i = NUM_M-1; i >= 0; i--) begin
      if (s_awvalid[i]) begin
        if (i > int'(r_last)) begin
          w_hi   = GW'(i);
          w_hi_v = 1'b1;
        end else begin
          w_lo   = GW'(i);
          w_lo_v = 1'b1;
        end
      end
    end
  end

  assign w_any  = w_hi_v | w_lo_v;
  assign w_pick = w_hi_v ? w_hi : w_lo;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_onehot[i] = (GW'(i) == w_pick);
    end
  end

  assign w_at_end = (r_cnt == r_len);
  assign w_w_hs   = (r_state == DATA) & s_wvalid[r_g] & m_wready;
  assign w_b_hs   = (r_state == RESP) & m_bvalid & s_bready[r_g];

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: if (w_any) w_state_nx = ADDR;
      ADDR: if (m_awready) w_state_nx = DATA;
      DATA: if (w_w_hs && w_at_end) w_state_nx = RESP;
      RESP: if (w_b_hs) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_g       <= '0;
      r_last    <= GW'(NUM_M-1);
      r_cnt     <= '0;
      r_len     <= '0;
      r_grant   <= '0;
      r_len_err <= '0;
    end else begin
      r_state <= w_state_nx;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_g     <= w_pick;
            r_grant <= w_onehot;
          end
        end
        ADDR: begin
          if (m_awready) begin
            r_len <= s_awlen[r_g*8 +: 8];
            r_cnt <= '0;
          end
        end
        DATA: begin
          if (w_w_hs) begin
            r_cnt <= r_cnt + 8'd1;
            // burst length follows AWLEN; a wrong WLAST is only flagged
            if (s_wlast[r_g] != w_at_end) begin
              r_len_err[r_g] <= 1'b1;
            end
          end
        end
        RESP: begin
          if (w_b_hs) begin
            r_last  <= r_g;
            r_grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bid     = '0;
    s_bresp   = '0;
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    unique case (r_state)
      ADDR: begin
        m_awvalid      = 1'b1;
        m_awid         = s_awid[r_g*ID_WIDTH +: ID_WIDTH];
        m_awaddr       = s_awaddr[r_g*ADDR_WIDTH +: ADDR_WIDTH];
        m_awlen        = s_awlen[r_g*8 +: 8];
        s_awready[r_g] = m_awready;
      end
      DATA: begin
        m_wvalid      = s_wvalid[r_g];
        m_wdata       = s_wdata[r_g*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb       = s_wstrb[r_g*STRB_WIDTH +: STRB_WIDTH];
        m_wlast       = w_at_end;
        s_wready[r_g] = m_wready;
      end
      RESP: begin
        m_bready                        = s_bready[r_g];
        s_bvalid[r_g]                   = m_bvalid;
        s_bid[r_g*ID_WIDTH +: ID_WIDTH] = m_bid;
        s_bresp[r_g*2 +: 2]             = m_bresp;
      end
      default: ;
    endcase
  end

  assign grant   = r_grant;
  assign len_err = r_len_err;

endmodule
